jtframe_frame_check: RTL

Parametrised frame checker for game-level simulation and on-board self-test. It sits on the core's pixel output (same tap as the video dumper) and counts frames. It computes a CRC-32 over every visible pixel of each frame, measures active width/height and flags geometry changes. Its MAXFRAME handling lets a bench stop after N frames without `ifdef` logic.

---
 rtl/jtframe_frame_check.sv | 127 ++++++++++++
 1 files changed

// File: rtl/jtframe_frame_check.sv
// Frame checker on the pixel tap: counts frames, CRC-32/BZIP2 over visible pixels,
// reports active geometry and flags lines whose width differs from the frame's first line.
module jtframe_frame_check #(
  parameter int unsigned COLORW   = 4,
  parameter int unsigned CNTW     = 12,
  parameter int unsigned MAXFRAME = 0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              pxl_cen,
  input  logic              pxl_hb,
  input  logic              pxl_vb,
  input  logic [COLORW-1:0] red,
  input  logic [COLORW-1:0] green,
  input  logic [COLORW-1:0] blue,
  output logic [31:0]       frame_cnt,
  output logic [31:0]       frame_crc,
  output logic              crc_valid,
  output logic [CNTW-1:0]   act_w,
  output logic [CNTW-1:0]   act_h,
  output logic              geom_err,
  output logic              frames_done
);

  localparam int unsigned REP  = (8 + COLORW - 1) / COLORW;
  localparam int unsigned EXPW = REP * COLORW;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  logic [31:0]     crc;
  logic [CNTW-1:0] line_px;
  logic [CNTW-1:0] line_cnt;
  logic [CNTW-1:0] ref_w;
  logic            first_seen;
  logic            prev_hb;
  logic            prev_vb;

  logic [EXPW-1:0] red_rep, green_rep, blue_rep;
  logic [23:0]     pix;
  logic [31:0]     crc_nxt;
  logic            active, hb_rise, vb_rise, line_close, width_bad;
  logic [CNTW-1:0] ref_w_nxt, line_cnt_nxt;

  // Shift 24 pixel bits into the CRC, MSB first
  function automatic logic [31:0] crc24(input logic [31:0] c, input logic [23:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 23; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  // Channel expansion by MSB-first repetition, then truncation to 8 bits
  always_comb begin
    red_rep   = {REP{red}};
    green_rep = {REP{green}};
    blue_rep  = {REP{blue}};
    pix       = {red_rep[EXPW-1 -: 8], green_rep[EXPW-1 -: 8], blue_rep[EXPW-1 -: 8]};
    crc_nxt   = crc24(crc, pix);
  end

  // A pending line is closed by an hb rise or, failing that, by the vb rise itself
  always_comb begin
    active       = pxl_cen & ~pxl_hb & ~pxl_vb;
    hb_rise      = pxl_cen & pxl_hb & ~prev_hb;
    vb_rise      = pxl_cen & pxl_vb & ~prev_vb;
    line_close   = (hb_rise | vb_rise) & (line_px != '0);
    ref_w_nxt    = ref_w;
    line_cnt_nxt = line_cnt;
    width_bad    = 1'b0;
    if (line_close) begin
      if (!first_seen) ref_w_nxt = line_px;
      else width_bad = (line_px != ref_w);
      if (line_cnt != CNT_MAX) line_cnt_nxt = line_cnt + CNTW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc         <= CRC_INIT;
      line_px     <= '0;
      line_cnt    <= '0;
      ref_w       <= '0;
      first_seen  <= 1'b0;
      prev_hb     <= 1'b0;
      prev_vb     <= 1'b0;
      frame_cnt   <= '0;
      frame_crc   <= '0;
      crc_valid   <= 1'b0;
      act_w       <= '0;
      act_h       <= '0;
      geom_err    <= 1'b0;
      frames_done <= (MAXFRAME == 0);
    end else begin
      crc_valid <= 1'b0;
      if (pxl_cen) begin
        prev_hb <= pxl_hb;
        prev_vb <= pxl_vb;
      end
      if (active) begin
        crc <= crc_nxt;
        if (line_px != CNT_MAX) line_px <= line_px + CNTW'(1);
      end
      if (width_bad) geom_err <= 1'b1;
      if (line_close) line_px <= '0;
      if (vb_rise) begin
        frame_crc  <= crc ^ CRC_INIT;
        act_w      <= ref_w_nxt;
        act_h      <= line_cnt_nxt;
        frame_cnt  <= frame_cnt + 32'd1;
        crc_valid  <= 1'b1;
        if (frame_cnt + 32'd1 == 32'(MAXFRAME)) frames_done <= 1'b1;
        crc        <= CRC_INIT;
        line_cnt   <= '0;
        ref_w      <= '0;
        first_seen <= 1'b0;
      end else if (line_close) begin
        ref_w      <= ref_w_nxt;
        line_cnt   <= line_cnt_nxt;
        first_seen <= 1'b1;
      end
    end
  end

endmodule
